logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined successor to the two-input gate bank. Computes one of
//  eight bitwise functions on WIDTH-bit operands per transaction. Adds valid/ready
//  handshakes, a chain mode that feeds back the previous result, result flags and
//  a transaction counter. Sits between a producer and a consumer stream at the
//  datapath boundary.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=1)
//  CNT_W   16  width of the accepted-transaction counter (>=1)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      producer has a transaction
//  in_ready   out  1      block can accept; driven from a register only
//  in_op      in   3      logic_unit_pkg::op_e function select
//  in_chain   in   1      1: operand B = result of previous accepted transaction
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B; ignored when in_chain=1
//  out_valid  out  1      result available
//  out_ready  in   1      consumer accepts the result
//  out_res    out  WIDTH  result
//  out_zero   out  1      result == 0
//  out_ones   out  1      result == all ones
//  out_par    out  1      XOR-reduction (odd parity) of result
//  tx_count   out  CNT_W  number of accepted input transactions, mod 2**CNT_W
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_res/flags=0,
//    tx_count=0, prev-result register=0, skid empty, in_ready=1.
//  - Accept: in_valid & in_ready on a clock edge. Output transfer: out_valid & out_ready.
//  - Ops: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 NOT A, 5 NOT B, 6 XOR, 7 XNOR (bitwise).
//  - Result, out_zero, out_ones and out_par are computed at accept and registered
//    together. Flags always describe the out_res presented with them.
//  - Latency: 1 cycle. A result accepted at edge N is on out_* after edge N
//    when the output stage is empty or drains at edge N.
//  - Chain: the prev register loads each accepted result at accept time,
//    independent of output draining. in_chain=1 selects prev as B. NOT B then
//    yields ~prev. The first chain after reset uses B=0.
//  - Buffering: a main output register plus one skid register; up to 2 results are held.
//    in_ready = !skid_full (registered). Stalled output: 1st accept fills main,
//    2nd fills skid, then in_ready=0. A transfer refills main from skid, and
//    in_ready returns to 1 on the next edge.
//  - Simultaneous accept + transfer: with main full and skid empty, the new result
//    goes to main. With skid full, no accept is possible. Order is never changed.
//    No result is dropped or duplicated.
//  - out_* stay stable while out_valid=1 and out_ready=0.
//  - tx_count increments by 1 per accept, wraps 2**CNT_W-1 -> 0 without a flag.
//  - Reset mid-operation discards all held results and clears prev and tx_count immediately.
//  - in_op and in_a/in_b are sampled only on accept. X on them when in_valid=0 has no effect.
// STRUCTURE
//  - logic_unit_pkg: op_e enum (3-bit, values above) and a pure function
//    lu_eval(op_e, a, b) returning the WIDTH-bit result.
//  - Sub-module lu_skid_buf (params WIDTH+3): 2-entry valid/ready skid stage with
//    registered in_ready. The top holds op decode, chain mux, flags and counter.
// TESTING  (WIDTH=8, CNT_W=4)
//  - Reset: assert rst_n=0 mid-stream -> out_valid=0, tx_count=0, in_ready=1.
//    After release, the first chain XOR with a=0x12 gives 0x12.
//  - Op sweep, a=0xA5, b=0x3C, out_ready=1: AND 24, OR BD, NAND DB, NOR 42,
//    NOTA 5A, NOTB C3, XOR 99, XNOR 66. Each result appears 1 cycle after accept.
//    Flags are correct, e.g. XOR 99 par=0.
//  - Chain: XOR a=FF b=0F -> F0. Next: chain XOR a=F0 -> 00, zero=1.
//    Next: chain NOR a=00 -> FF, ones=1, par=0.
//  - Backpressure: out_ready=0 with in_valid=1 continuously -> 2 accepts, then
//    in_ready=0. Release -> results emerge in order, out_* held stable while stalled.
//  - Random valid/ready throttling, 1000 txns vs lu_eval model: no loss, dup or
//    reorder. Throughput is 1/cycle when out_ready=1.
//  - Counter wrap: 17 accepts -> tx_count=1. Check it does not increment on
//    in_valid=1 with in_ready=0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types and the combinational evaluation function for the logic unit.
package logic_unit_pkg;

    // Widest operand the evaluation function handles; the top zero-extends and truncates.
    localparam int LU_MAX_W = 64;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_NOTA = 3'd4,
        OP_NOTB = 3'd5,
        OP_XOR  = 3'd6,
        OP_XNOR = 3'd7
    } op_e;

    typedef struct packed {
        logic zero;
        logic ones;
        logic par;
    } lu_flags_t;

    // Pure bitwise evaluation; the caller keeps only its low WIDTH bits.
    function automatic logic [LU_MAX_W-1:0] lu_eval(input op_e op,
                                                    input logic [LU_MAX_W-1:0] a,
                                                    input logic [LU_MAX_W-1:0] b);
        logic [LU_MAX_W-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_NOTA: r = ~a;
            OP_NOTB: r = ~b;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lu_skid_buf.sv
// Two-entry valid/ready stage: a main output register backed by one skid register.
// Handshake: a word moves on any edge where valid and ready are both high; the
// sender holds data while valid is high and ready low. in_ready is a register
// equal to "skid empty", so it never depends combinationally on out_ready.
module lu_skid_buf #(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          r_main_valid;
    logic [DW-1:0] r_main_data;
    logic          r_skid_valid;
    logic [DW-1:0] r_skid_data;
    logic          r_in_ready;

    logic w_accept;
    logic w_xfer;
    logic w_skid_full_next;

    assign w_accept = in_valid && r_in_ready;
    assign w_xfer   = r_main_valid && out_ready;

    // Skid holds a word after this edge only if main stays occupied and something lands in skid.
    assign w_skid_full_next = r_main_valid && !w_xfer && (r_skid_valid || w_accept);

    // Main/skid occupancy and data; skid always drains into main first to keep order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b1;
        end else begin
            if (!r_main_valid || w_xfer) begin
                if (r_skid_valid) begin
                    r_main_data  <= r_skid_data;
                    r_main_valid <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_main_data  <= in_data;
                    r_main_valid <= 1'b1;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_data  <= in_data;
                r_skid_valid <= 1'b1;
            end
            r_in_ready <= !w_skid_full_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: op decode, chain feedback, result flags and an
// accept counter in front of a two-entry output skid stage. WIDTH must not exceed LU_MAX_W.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              in_op,
    input  logic             in_chain,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_par,
    output logic [CNT_W-1:0] tx_count
);

    localparam int DW = WIDTH + 3;

    logic [WIDTH-1:0]    r_prev;
    logic [CNT_W-1:0]    r_tx_count;

    logic                w_in_ready;
    logic                w_accept;
    logic [WIDTH-1:0]    w_b;
    logic [LU_MAX_W-1:0] w_eval;
    logic [WIDTH-1:0]    w_res;
    lu_flags_t           w_flags;
    logic [DW-1:0]       w_buf_in;
    logic [DW-1:0]       w_buf_out;

    assign w_accept = in_valid && w_in_ready;

    // Chain mode replaces operand B with the previous accepted result.
    assign w_b    = in_chain ? r_prev : in_b;
    assign w_eval = lu_eval(in_op, LU_MAX_W'(in_a), LU_MAX_W'(w_b));
    assign w_res  = w_eval[WIDTH-1:0];

    if (WIDTH < LU_MAX_W) begin : g_hi
        logic w_unused_hi;
        assign w_unused_hi = ^w_eval[LU_MAX_W-1:WIDTH];
    end

    // Flags are computed alongside the result so they travel with it through the buffer.
    assign w_flags.zero = ~|w_res;
    assign w_flags.ones = &w_res;
    assign w_flags.par  = ^w_res;
    assign w_buf_in     = {w_res, w_flags};

    // Previous-result register loads at accept time, regardless of output draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else if (w_accept) begin
            r_prev <= w_res;
        end
    end

    // Accepted-transaction counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_count <= '0;
        end else if (w_accept) begin
            r_tx_count <= r_tx_count + CNT_W'(1);
        end
    end

    lu_skid_buf #(
        .DW(DW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_buf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_buf_out)
    );

    assign in_ready = w_in_ready;
    assign out_res  = w_buf_out[DW-1:3];
    assign out_zero = w_buf_out[2];
    assign out_ones = w_buf_out[1];
    assign out_par  = w_buf_out[0];
    assign tx_count = r_tx_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomly throttled checks of logic_unit_pipe at WIDTH=8, CNT_W=4.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int NVEC  = 18;
    localparam int NRAND = 1000;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    op_e           in_op;
    logic          in_chain;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_res;
    logic          out_zero;
    logic          out_ones;
    logic          out_par;
    logic [CW-1:0] tx_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        op_e        op;
        logic       chain;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       o;
        logic       p;
    } vec_t;

    vec_t vecs[NVEC];
    logic [W+2:0] exp_q[$];

    logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_chain  (in_chain),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_par   (out_par),
        .tx_count  (tx_count)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [7:0] model_eval(input op_e op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_NOTA: return ~a;
            OP_NOTB: return ~b;
            OP_XOR:  return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic logic [W+2:0] pack_exp(input logic [7:0] r);
        return {r, (r == 8'h00), (r == 8'hFF), ^r};
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_chain  = 1'b0;
        in_op     = OP_AND;
        in_a      = '0;
        in_b      = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic drive(input op_e op, input logic ch, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_chain = ch;
        in_a     = a;
        in_b     = b;
    endtask

    // Random throttled traffic against the model and expected queue
    task automatic run_random();
        int         sent = 0;
        int         got  = 0;
        int         cyc  = 0;
        logic [7:0] m_prev = 8'h00;
        logic       acc, xf, held_vld;
        logic [W+3:0] held;
        logic [7:0] r;
        held_vld = 1'b0;
        held     = '0;
        while (got < NRAND && cyc < 20000) begin
            if (!in_valid && sent < NRAND && $urandom_range(0, 3) != 0) begin
                drive(op_e'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            if (held_vld) chk("rand_stable", {out_valid, out_res, out_zero, out_ones, out_par}, held);
            if (xf) begin
                chk("rand_q_nonempty", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("rand_out", {out_res, out_zero, out_ones, out_par}, exp_q.pop_front());
                end
                got++;
            end
            if (acc) begin
                r = model_eval(in_op, in_a, in_chain ? m_prev : in_b);
                m_prev = r;
                exp_q.push_back(pack_exp(r));
                sent++;
            end
            held_vld = out_valid && !out_ready;
            held     = {out_valid, out_res, out_zero, out_ones, out_par};
            tick();
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("rand_sent", sent, NRAND);
        chk("rand_got", got, NRAND);
        chk("rand_q_empty", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0]  = '{OP_OR,   1'b1, 8'h30, 8'hFF, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_AND,  1'b0, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{OP_OR,   1'b0, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{OP_NAND, 1'b0, 8'hA5, 8'h3C, 8'hDB, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_NOR,  1'b0, 8'hA5, 8'h3C, 8'h42, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{OP_NOTA, 1'b0, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_NOTB, 1'b0, 8'hA5, 8'h3C, 8'hC3, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_XOR,  1'b0, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_XNOR, 1'b0, 8'hA5, 8'h3C, 8'h66, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_XOR,  1'b0, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{OP_XOR,  1'b1, 8'hF0, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{OP_NOR,  1'b1, 8'h00, 8'h55, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{OP_AND,  1'b0, 8'h01, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{OP_OR,   1'b0, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{OP_NOTB, 1'b1, 8'h11, 8'hAA, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{OP_AND,  1'b1, 8'hFF, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{OP_XNOR, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{OP_NAND, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};

        // Reset state
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_tx_count",  tx_count,  0);
        chk("rst_out_res",   out_res,   0);
        chk("rst_flags",     {out_zero, out_ones, out_par}, 0);

        // Table: one accept per cycle, result checked one edge later
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].op, vecs[i].chain, vecs[i].a, vecs[i].b);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, 1);
            tick();
            chk($sformatf("tbl%0d_valid", i), out_valid, 1);
            chk($sformatf("tbl%0d_res", i), out_res, vecs[i].res);
            chk($sformatf("tbl%0d_flags", i), {out_zero, out_ones, out_par},
                {vecs[i].z, vecs[i].o, vecs[i].p});
        end
        in_valid = 1'b0;
        tick();
        chk("tbl_drained", out_valid, 0);
        chk("tbl_tx_count", tx_count, NVEC % 16);

        // Backpressure: two accepts, then in_ready drops and output holds
        out_ready = 1'b0;
        drive(OP_AND, 1'b0, 8'hF0, 8'h3C);
        tick();
        chk("bp_first_res", out_res, 8'h30);
        chk("bp_ready_after1", in_ready, 1);
        drive(OP_OR, 1'b0, 8'h01, 8'h02);
        tick();
        chk("bp_ready_after2", in_ready, 0);
        drive(OP_XOR, 1'b0, 8'hAA, 8'h55);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_res", out_res, 8'h30);
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_tx", tx_count, (NVEC + 2) % 16);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_res1", out_res, 8'h03);
        chk("bp_rel_ready", in_ready, 1);
        chk("bp_rel_tx", tx_count, (NVEC + 2) % 16);
        tick();
        chk("bp_rel_res2", out_res, 8'hFF);
        chk("bp_rel_ones", out_ones, 1);
        chk("bp_rel_tx2", tx_count, (NVEC + 3) % 16);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", out_valid, 0);

        // Random throttled stream from a clean state
        do_reset();
        run_random();

        // Counter wrap
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            drive(op_e'(k % 8), 1'b0, 8'(k), 8'h5A);
            tick();
            if (k == 14) chk("wrap_tx15", tx_count, 4'hF);
        end
        chk("wrap_tx17", tx_count, 1);

        // Asynchronous reset with results held, then first chain uses B=0
        out_ready = 1'b0;
        drive(OP_OR, 1'b0, 8'h0F, 8'hF0);
        tick();
        tick();
        chk("mid_ready_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_tx", tx_count, 0);
        chk("mid_rst_ready", in_ready, 1);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("mid_post_valid", out_valid, 0);
        out_ready = 1'b1;
        drive(OP_XOR, 1'b1, 8'h12, 8'hFF);
        tick();
        chk("mid_chain_valid", out_valid, 1);
        chk("mid_chain_res", out_res, 8'h12);
        chk("mid_chain_flags", {out_zero, out_ones, out_par}, 3'b000);
        chk("mid_chain_tx", tx_count, 1);
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
